// File: rtl/reg_port_arb_pkg.sv
// Shared constants for the register-file port arbiter.
// Default widths and requester indices.
package reg_port_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int AW_DEF     = 3;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage

// File: rtl/reg_port_arb_rr_arb2.sv
// Two-way round-robin arbiter.
// Single pointer bit; grants are combinational and masked during reset.
module rr_arb2
    import reg_port_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic       ptr_q;
    logic       ptr_d;
    logic [1:0] gnt;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (!rst) begin
            if (req_i == 2'b11) begin
                gnt[ptr_q] = 1'b1;
            end else begin
                gnt = req_i;
            end
        end
        // The loser of this grant gets priority next time.
        if (gnt[REQ0]) begin
            ptr_d = 1'b1;
        end else if (gnt[REQ1]) begin
            ptr_d = 1'b0;
        end
    end

    assign gnt_o = gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_port_arb.sv
// Arbitrates two read and two write requesters onto one register-file port
// pair, with a one-cycle read response and same-cycle write bypass.
module reg_port_arb
    import reg_port_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        RD_REQ,
    input  logic [AW-1:0]     RD_SR1_0,
    input  logic [AW-1:0]     RD_SR2_0,
    input  logic [AW-1:0]     RD_SR1_1,
    input  logic [AW-1:0]     RD_SR2_1,
    output logic [1:0]        RD_GNT,
    output logic [1:0]        RSP_VALID,
    output logic [DATA_W-1:0] RSP_SR1_DATA,
    output logic [DATA_W-1:0] RSP_SR2_DATA,
    input  logic [1:0]        WR_REQ,
    input  logic [AW-1:0]     WR_DR_0,
    input  logic [AW-1:0]     WR_DR_1,
    input  logic [DATA_W-1:0] WR_DATA_0,
    input  logic [DATA_W-1:0] WR_DATA_1,
    output logic [1:0]        WR_GNT,
    output logic              RF_LD_REG,
    output logic [AW-1:0]     RF_DR,
    output logic [AW-1:0]     RF_SR1,
    output logic [AW-1:0]     RF_SR2,
    output logic [DATA_W-1:0] RF_DATA,
    input  logic [DATA_W-1:0] RF_SR1_OUT,
    input  logic [DATA_W-1:0] RF_SR2_OUT
);

    logic [1:0]        rd_gnt;
    logic [1:0]        wr_gnt;
    logic [1:0]        rsp_vld_q;
    logic              byp1_q;
    logic              byp1_d;
    logic              byp2_q;
    logic              byp2_d;
    logic [DATA_W-1:0] byp_data_q;
    logic              rsp_any;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (RD_REQ),
        .gnt_o (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (WR_REQ),
        .gnt_o (wr_gnt)
    );

    assign RD_GNT = rd_gnt;
    assign WR_GNT = wr_gnt;

    always_comb begin
        RF_SR1 = '0;
        RF_SR2 = '0;
        unique case (1'b1)
            rd_gnt[REQ0]: begin
                RF_SR1 = RD_SR1_0;
                RF_SR2 = RD_SR2_0;
            end
            rd_gnt[REQ1]: begin
                RF_SR1 = RD_SR1_1;
                RF_SR2 = RD_SR2_1;
            end
            default: ;
        endcase
    end

    always_comb begin
        RF_DR   = '0;
        RF_DATA = '0;
        unique case (1'b1)
            wr_gnt[REQ0]: begin
                RF_DR   = WR_DR_0;
                RF_DATA = WR_DATA_0;
            end
            wr_gnt[REQ1]: begin
                RF_DR   = WR_DR_1;
                RF_DATA = WR_DATA_1;
            end
            default: ;
        endcase
    end

    assign RF_LD_REG = |wr_gnt;

    // The RF returns pre-write data for a same-cycle hit, so forward it.
    assign byp1_d = (|rd_gnt) & RF_LD_REG & (RF_SR1 == RF_DR);
    assign byp2_d = (|rd_gnt) & RF_LD_REG & (RF_SR2 == RF_DR);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q  <= 2'b00;
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rsp_vld_q  <= rd_gnt;
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            byp_data_q <= RF_DATA;
        end
    end

    assign RSP_VALID = rst ? 2'b00 : rsp_vld_q;
    assign rsp_any   = |RSP_VALID;

    assign RSP_SR1_DATA = !rsp_any ? '0 :
                          byp1_q   ? byp_data_q : RF_SR1_OUT;
    assign RSP_SR2_DATA = !rsp_any ? '0 :
                          byp2_q   ? byp_data_q : RF_SR2_OUT;

endmodule
